// File: rtl/lock_verify_if.sv
// Interface between the keypad digit collector and the lock controller.
// The master side supplies the entered code and requests. The slave side
// (the lock controller) returns the lock status and the event pulses.
interface lock_verify_if #(
  parameter int unsigned CODE_W = 24
);
  logic [CODE_W-1:0] number_in;
  logic              number_valid;
  logic              change_req;
  logic              unlock;
  logic              alarm;
  logic [3:0]        fail_cnt;
  logic              code_err;
  logic              pwd_changed;

  modport master (
    output number_in, number_valid, change_req,
    input  unlock, alarm, fail_cnt, code_err, pwd_changed
  );

  modport slave (
    input  number_in, number_valid, change_req,
    output unlock, alarm, fail_cnt, code_err, pwd_changed
  );
endinterface

// File: rtl/lock_verify.sv
// Password checker and lock controller.
// Compares each completed keypad code with the stored password and drives
// the unlock output. Consecutive wrong codes are counted; reaching MAX_FAIL
// starts a timed alarm lockout. While the lock is open, a two-entry
// password change can be started, and it commits only when both entries agree.
module lock_verify #(
  parameter int unsigned          CODE_W         = 24,
  parameter logic [CODE_W-1:0]    DEFAULT_CODE   = 24'h123456,
  parameter int unsigned          MAX_FAIL       = 3,
  parameter int unsigned          UNLOCK_CYCLES  = 50_000_000,
  parameter int unsigned          LOCKOUT_CYCLES = 500_000_000,
  parameter int unsigned          CNT_W          = 32
) (
  input  logic           clk,
  input  logic           rst,
  lock_verify_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OPEN    = 3'd1,
    ST_NEW1    = 3'd2,
    ST_NEW2    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  // Terminal counts: a state is left on the edge where the timer holds these values.
  localparam logic [CNT_W-1:0] UNLOCK_LAST  = CNT_W'(UNLOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCKOUT_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       MAX_FAIL_C   = 4'(MAX_FAIL);

  state_t            state_q;
  logic [CNT_W-1:0]  timer_q;
  logic [CODE_W-1:0] password_q;
  logic [CODE_W-1:0] temp_q;
  logic              unlock_q;
  logic              alarm_q;
  logic [3:0]        fail_cnt_q;
  logic              code_err_q;
  logic              pwd_changed_q;
  logic [3:0]        fail_cnt_d;

  // Wrong-code count after one more failure, held at MAX_FAIL.
  always_comb begin
    fail_cnt_d = fail_cnt_q;
    if (fail_cnt_q < MAX_FAIL_C) begin
      fail_cnt_d = fail_cnt_q + 4'd1;
    end else begin
      fail_cnt_d = MAX_FAIL_C;
    end
  end

  // Lock FSM: state, timer, stored password and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      password_q    <= DEFAULT_CODE;
      temp_q        <= '0;
      unlock_q      <= 1'b0;
      alarm_q       <= 1'b0;
      fail_cnt_q    <= 4'd0;
      code_err_q    <= 1'b0;
      pwd_changed_q <= 1'b0;
    end else begin
      // Event outputs are single-cycle pulses.
      code_err_q    <= 1'b0;
      pwd_changed_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          // number_valid takes priority over change_req, which is ignored here.
          if (bus.number_valid) begin
            if (bus.number_in == password_q) begin
              state_q    <= ST_OPEN;
              unlock_q   <= 1'b1;
              fail_cnt_q <= 4'd0;
            end else begin
              code_err_q <= 1'b1;
              fail_cnt_q <= fail_cnt_d;
              if (fail_cnt_d == MAX_FAIL_C) begin
                state_q <= ST_LOCKOUT;
                alarm_q <= 1'b1;
              end
            end
          end
        end

        ST_OPEN: begin
          // change_req beats the unlock timeout. Codes are ignored while open.
          if (bus.change_req) begin
            state_q <= ST_NEW1;
            timer_q <= '0;
          end else if (timer_q == UNLOCK_LAST) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            unlock_q <= 1'b0;
          end else begin
            timer_q <= timer_q + TIMER_ONE;
          end
        end

        ST_NEW1: begin
          if (bus.number_valid) begin
            temp_q  <= bus.number_in;
            state_q <= ST_NEW2;
            timer_q <= '0;
          end else if (timer_q == UNLOCK_LAST) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            unlock_q <= 1'b0;
          end else begin
            timer_q <= timer_q + TIMER_ONE;
          end
        end

        ST_NEW2: begin
          // A confirm mismatch reports code_err but is not counted as a failure.
          if (bus.number_valid) begin
            if (bus.number_in == temp_q) begin
              password_q    <= temp_q;
              pwd_changed_q <= 1'b1;
            end else begin
              code_err_q <= 1'b1;
            end
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            unlock_q <= 1'b0;
          end else if (timer_q == UNLOCK_LAST) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            unlock_q <= 1'b0;
          end else begin
            timer_q <= timer_q + TIMER_ONE;
          end
        end

        ST_LOCKOUT: begin
          // All input is ignored until the lockout period expires.
          if (timer_q == LOCKOUT_LAST) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            alarm_q    <= 1'b0;
            fail_cnt_q <= 4'd0;
          end else begin
            timer_q <= timer_q + TIMER_ONE;
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          timer_q  <= '0;
          unlock_q <= 1'b0;
          alarm_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.unlock      = unlock_q;
  assign bus.alarm       = alarm_q;
  assign bus.fail_cnt    = fail_cnt_q;
  assign bus.code_err    = code_err_q;
  assign bus.pwd_changed = pwd_changed_q;

endmodule

// File: tb/tb_lock_verify.sv
// Directed testbench for lock_verify using short unlock and lockout periods.
module tb_lock_verify;

  localparam int unsigned UNLOCK_CYCLES  = 8;
  localparam int unsigned LOCKOUT_CYCLES = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  lock_verify_if #(.CODE_W(24)) bus ();

  lock_verify #(
    .CODE_W         (24),
    .DEFAULT_CODE   (24'h123456),
    .MAX_FAIL       (3),
    .UNLOCK_CYCLES  (UNLOCK_CYCLES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .CNT_W          (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a code for one cycle; outputs afterwards reflect the response.
  task automatic enter_code(input logic [23:0] code);
    bus.number_in    = code;
    bus.number_valid = 1'b1;
    tick();
    bus.number_valid = 1'b0;
    bus.number_in    = 24'h000000;
  endtask

  // Pulse change_req for one cycle.
  task automatic request_change();
    bus.change_req = 1'b1;
    tick();
    bus.change_req = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    rst              = 1'b0;
    bus.number_in    = 24'h000000;
    bus.number_valid = 1'b0;
    bus.change_req   = 1'b0;
    tick();
    tick();
    check_eq("rst_unlock",   32'(bus.unlock), 32'd0);
    check_eq("rst_alarm",    32'(bus.alarm), 32'd0);
    check_eq("rst_fail_cnt", 32'(bus.fail_cnt), 32'd0);
    check_eq("rst_code_err", 32'(bus.code_err), 32'd0);
    check_eq("rst_pwd_chg",  32'(bus.pwd_changed), 32'd0);
    rst = 1'b1;
    tick();

    // 1. Correct code: unlock for exactly UNLOCK_CYCLES cycles.
    enter_code(24'h123456);
    check_eq("s1_unlock",   32'(bus.unlock), 32'd1);
    check_eq("s1_fail_cnt", 32'(bus.fail_cnt), 32'd0);
    check_eq("s1_code_err", 32'(bus.code_err), 32'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      check_eq("s1_unlock_held", 32'(bus.unlock), 32'd1);
    end
    tick();
    check_eq("s1_unlock_end", 32'(bus.unlock), 32'd0);

    // 2. Wrong codes lead to lockout; lockout ignores the correct code.
    enter_code(24'h000001);
    check_eq("s2_err1",  32'(bus.code_err), 32'd1);
    check_eq("s2_cnt1",  32'(bus.fail_cnt), 32'd1);
    tick();
    check_eq("s2_err1_pulse", 32'(bus.code_err), 32'd0);
    enter_code(24'h000001);
    check_eq("s2_err2",  32'(bus.code_err), 32'd1);
    check_eq("s2_cnt2",  32'(bus.fail_cnt), 32'd2);
    check_eq("s2_alarm_pre", 32'(bus.alarm), 32'd0);
    enter_code(24'h000001);
    check_eq("s2_err3",  32'(bus.code_err), 32'd1);
    check_eq("s2_alarm", 32'(bus.alarm), 32'd1);
    check_eq("s2_cnt3",  32'(bus.fail_cnt), 32'd3);
    enter_code(24'h123456);
    check_eq("s2_lock_unlock", 32'(bus.unlock), 32'd0);
    check_eq("s2_lock_err",    32'(bus.code_err), 32'd0);
    check_eq("s2_lock_cnt",    32'(bus.fail_cnt), 32'd3);
    for (int i = 2; i < 16; i++) begin
      tick();
    end
    check_eq("s2_alarm_held", 32'(bus.alarm), 32'd1);
    tick();
    check_eq("s2_alarm_end", 32'(bus.alarm), 32'd0);
    check_eq("s2_cnt_clear", 32'(bus.fail_cnt), 32'd0);
    enter_code(24'h123456);
    check_eq("s2_unlock_after", 32'(bus.unlock), 32'd1);
    repeat (8) tick();
    check_eq("s2_relock", 32'(bus.unlock), 32'd0);

    // 3. Correct code clears a partial failure count.
    enter_code(24'h654321);
    enter_code(24'h012345);
    check_eq("s3_cnt2", 32'(bus.fail_cnt), 32'd2);
    enter_code(24'h123456);
    check_eq("s3_unlock", 32'(bus.unlock), 32'd1);
    check_eq("s3_cnt0",   32'(bus.fail_cnt), 32'd0);
    repeat (8) tick();
    check_eq("s3_relock", 32'(bus.unlock), 32'd0);

    // 4. Password change to 987654.
    enter_code(24'h123456);
    request_change();
    check_eq("s4_unlock_new1", 32'(bus.unlock), 32'd1);
    enter_code(24'h987654);
    check_eq("s4_unlock_new2", 32'(bus.unlock), 32'd1);
    check_eq("s4_no_chg_yet",  32'(bus.pwd_changed), 32'd0);
    enter_code(24'h987654);
    check_eq("s4_pwd_chg", 32'(bus.pwd_changed), 32'd1);
    check_eq("s4_unlock0", 32'(bus.unlock), 32'd0);
    tick();
    check_eq("s4_pwd_chg_pulse", 32'(bus.pwd_changed), 32'd0);
    enter_code(24'h123456);
    check_eq("s4_old_err",    32'(bus.code_err), 32'd1);
    check_eq("s4_old_unlock", 32'(bus.unlock), 32'd0);
    enter_code(24'h987654);
    check_eq("s4_new_unlock", 32'(bus.unlock), 32'd1);
    check_eq("s4_new_cnt",    32'(bus.fail_cnt), 32'd0);

    // 6. Reset while open: unlock drops at once, password reverts.
    tick();
    rst = 1'b0;
    #2;
    check_eq("s6_async_unlock", 32'(bus.unlock), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    enter_code(24'h987654);
    check_eq("s6_changed_lost", 32'(bus.unlock), 32'd0);
    check_eq("s6_changed_err",  32'(bus.code_err), 32'd1);
    enter_code(24'h123456);
    check_eq("s6_default_unlock", 32'(bus.unlock), 32'd1);

    // 5. Change mismatch keeps the password; change timeout returns to idle.
    request_change();
    enter_code(24'h111111);
    enter_code(24'h222222);
    check_eq("s5_mis_err",    32'(bus.code_err), 32'd1);
    check_eq("s5_mis_unlock", 32'(bus.unlock), 32'd0);
    check_eq("s5_mis_chg",    32'(bus.pwd_changed), 32'd0);
    check_eq("s5_mis_cnt",    32'(bus.fail_cnt), 32'd0);
    enter_code(24'h111111);
    check_eq("s5_not_new", 32'(bus.unlock), 32'd0);
    enter_code(24'h123456);
    check_eq("s5_old_ok", 32'(bus.unlock), 32'd1);
    request_change();
    for (int i = 1; i < 8; i++) begin
      tick();
    end
    check_eq("s5_to_held", 32'(bus.unlock), 32'd1);
    tick();
    check_eq("s5_to_unlock", 32'(bus.unlock), 32'd0);
    check_eq("s5_to_alarm",  32'(bus.alarm), 32'd0);
    enter_code(24'h123456);
    check_eq("s5_final_unlock", 32'(bus.unlock), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
